// File: rtl/t02_mem_pkg.sv
// Shared types and defaults for the multi-channel memory request arbiter.
// States, default widths and conventional channel indices.
package t02_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam int CH_IFETCH = 0;
  localparam int CH_DATA   = 1;

endpackage

// File: rtl/t02_arb_select.sv
// Combinational winner select for the memory arbiter.
// T02_MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise index 0 wins.
module t02_arb_select
  import t02_mem_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  input  logic              i_enable,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  always_comb begin
    o_valid = i_enable && (|i_req);
    o_idx   = '0;
`ifdef T02_MEM_ARB_ROUND_ROBIN_EN
    // Walk offsets high to low so the nearest requester after i_ptr wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (i_req[IDX_W'(j)]) o_idx = IDX_W'(j);
    end
`else
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (i_req[IDX_W'(k)]) o_idx = IDX_W'(k);
    end
`endif
  end

`ifndef T02_MEM_ARB_ROUND_ROBIN_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`endif

endmodule

// File: rtl/t02_mem_arbiter.sv
// NUM_CH-way memory request arbiter onto one RAM port, one access in flight.
// Define T02_MEM_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module t02_mem_arbiter
  import t02_mem_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wen,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_ready,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic [$clog2(NUM_CH)-1:0]      grant_id,
  output logic                           arb_busy,
  output logic [ADDR_W-1:0]              ramaddr,
  output logic [DATA_W-1:0]              ramstore,
  output logic                           Ren,
  output logic                           Wen,
  input  logic [DATA_W-1:0]              ramload,
  input  logic                           busy_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_t              r_state;
  logic [IDX_W-1:0]    r_gid;
  logic                r_wflag;
  logic [ADDR_W-1:0]   r_ramaddr;
  logic [DATA_W-1:0]   r_ramstore;
  logic                r_ren;
  logic                r_wen;
  logic [NUM_CH-1:0]   r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;

  logic [IDX_W-1:0]    w_ptr;
  logic [IDX_W-1:0]    w_idx;
  logic                w_valid;

`ifdef T02_MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  t02_arb_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_sel (
    .i_req    (ch_req),
    .i_ptr    (w_ptr),
    .i_enable (enable),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Strobes and ready are registered one state ahead so they line up
  // with ISSUE and DONE respectively.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gid      <= '0;
      r_wflag    <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_ready    <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
`ifdef T02_MEM_ARB_ROUND_ROBIN_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_ready <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gid      <= w_idx;
            r_ramaddr  <= ch_addr[w_idx];
            r_ramstore <= ch_wdata[w_idx];
            r_wflag    <= ch_wen[w_idx];
            r_ren      <= ~ch_wen[w_idx];
            r_wen      <= ch_wen[w_idx];
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (!busy_o) begin
            if (!r_wflag) r_rdata <= ramload;
            r_ready <= NUM_CH'(1) << r_gid;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
`ifdef T02_MEM_ARB_ROUND_ROBIN_EN
          r_ptr <= (r_gid == IDX_W'(NUM_CH - 1)) ? '0 : r_gid + 1'b1;
`endif
        end
      endcase
    end
  end

  assign ch_ready = r_ready;
  assign ch_rdata = r_rdata;
  assign grant_id = r_gid;
  assign arb_busy = r_busy;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign Ren      = r_ren;
  assign Wen      = r_wen;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Self-checking bench for t02_mem_arbiter (2-channel and 3-channel builds).
// Expected grants come from a priority-order model of the arbitration rules.
module tb_t02_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             enable;
  logic [1:0]       ch_req;
  logic [1:0]       ch_wen;
  logic [1:0][31:0] ch_addr;
  logic [1:0][31:0] ch_wdata;
  logic [1:0]       ch_ready;
  logic [31:0]      ch_rdata;
  logic [0:0]       grant_id;
  logic             arb_busy;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic             Ren;
  logic             Wen;
  logic [31:0]      ramload;
  logic             busy_o;

  logic             use_auto;
  logic             ram_init;
  logic [31:0]      ramload_drv;
  logic [31:0]      ram [16];

  assign ramload = use_auto ? ram[ramaddr[5:2]] : ramload_drv;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end else if (Wen) begin
      ram[ramaddr[5:2]] <= ramstore;
    end
  end

  t02_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ch_req(ch_req), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata), .grant_id(grant_id),
    .arb_busy(arb_busy), .ramaddr(ramaddr), .ramstore(ramstore),
    .Ren(Ren), .Wen(Wen), .ramload(ramload), .busy_o(busy_o)
  );

  logic [2:0]       req3;
  logic [2:0]       wen3;
  logic [2:0][31:0] addr3;
  logic [2:0][31:0] wdata3;
  logic [2:0]       ready3;
  logic [31:0]      rdata3;
  logic [1:0]       grant3;
  logic             busy3;
  logic [31:0]      raddr3;
  logic [31:0]      rstore3;
  logic             ren3;
  logic             wen3o;
  logic [31:0]      ramload3;
  logic             busyo3;

  t02_mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable),
    .ch_req(req3), .ch_wen(wen3), .ch_addr(addr3), .ch_wdata(wdata3),
    .ch_ready(ready3), .ch_rdata(rdata3), .grant_id(grant3),
    .arb_busy(busy3), .ramaddr(raddr3), .ramstore(rstore3),
    .Ren(ren3), .Wen(wen3o), .ramload(ramload3), .busy_o(busyo3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Winner = first requester in priority order starting at ptr.
  function automatic int pick(input int n, input logic [7:0] req, input int ptr);
`ifdef T02_MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < n; k++) if (req[(ptr + k) % n]) return (ptr + k) % n;
`else
    for (int k = 0; k < n; k++) if (req[k]) return k;
`endif
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; busy_o = 1'b0;
    ch_req = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
    req3 = '0; wen3 = '0; addr3 = '0; wdata3 = '0; ramload3 = '0; busyo3 = 1'b0;
    use_auto = 1'b0; ram_init = 1'b0; ramload_drv = '0;
    tick(); tick();
    n_cmp++; if (ch_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", ch_ready); end
    n_cmp++; if (ch_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", ch_rdata); end
    n_cmp++; if (ramaddr !== 32'h0) begin n_bad++; $display("FAIL rst_ramaddr: got %h want 0", ramaddr); end
    n_cmp++; if (ramstore !== 32'h0) begin n_bad++; $display("FAIL rst_ramstore: got %h want 0", ramstore); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL rst_grant: got %b want 0", grant_id); end
    n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", arb_busy); end
    n_cmp++; if ({Ren, Wen} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {Ren, Wen}); end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    ch_req = 2'b01; ch_wen = 2'b00; ch_addr[0] = 32'h10;
    ramload_drv = 32'hDEAD_BEEF; busy_o = 1'b0;
    tick();
    n_cmp++; if ({Ren, Wen} !== 2'b10) begin n_bad++; $display("FAIL rd_issue_strobes: got %b want 10", {Ren, Wen}); end
    n_cmp++; if (ramaddr !== 32'h10) begin n_bad++; $display("FAIL rd_addr: got %h want 10", ramaddr); end
    n_cmp++; if (arb_busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b want 1", arb_busy); end
    tick();
    n_cmp++; if (Ren !== 1'b0) begin n_bad++; $display("FAIL rd_ren_one_cycle: got %b want 0", Ren); end
    tick();
    n_cmp++; if (ch_ready !== 2'b01) begin n_bad++; $display("FAIL rd_ready: got %b want 01", ch_ready); end
    n_cmp++; if (ch_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", ch_rdata); end
    ch_req = 2'b00;
    tick();
    n_cmp++; if (ch_ready !== 2'b00) begin n_bad++; $display("FAIL rd_ready_pulse: got %b want 00", ch_ready); end
  endtask

  task automatic test_write_wait;
    int early;
    early = 0;
    ch_req = 2'b10; ch_wen = 2'b10; ch_addr[1] = 32'h20;
    ch_wdata[1] = 32'h1234_5678; busy_o = 1'b1; ramload_drv = 32'h0BAD_0BAD;
    tick();
    n_cmp++; if ({Ren, Wen} !== 2'b01) begin n_bad++; $display("FAIL wr_strobes: got %b want 01", {Ren, Wen}); end
    n_cmp++; if (ramstore !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_store: got %h want 12345678", ramstore); end
    n_cmp++; if (ramaddr !== 32'h20) begin n_bad++; $display("FAIL wr_addr: got %h want 20", ramaddr); end
    n_cmp++; if (grant_id !== 1'b1) begin n_bad++; $display("FAIL wr_grant: got %b want 1", grant_id); end
    tick();
    n_cmp++; if (Wen !== 1'b0) begin n_bad++; $display("FAIL wr_wen_one_cycle: got %b want 0", Wen); end
    repeat (5) begin
      tick();
      if (ch_ready !== 2'b00) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL wr_wait_hold: got %0d early pulses want 0", early); end
    busy_o = 1'b0;
    tick();
    n_cmp++; if (ch_ready !== 2'b10) begin n_bad++; $display("FAIL wr_ready: got %b want 10", ch_ready); end
    n_cmp++; if (ch_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want deadbeef", ch_rdata); end
    ch_req = 2'b00; ch_wen = 2'b00;
    tick();
  endtask

  task automatic test_contention;
    int m_ptr;
    int exp;
    bit got;
    pulse_rst();
    m_ptr = 0;
    ch_req = 2'b11; ch_wen = 2'b00; ch_addr[0] = 32'h40; ch_addr[1] = 32'h44;
    ramload_drv = 32'h7777_0000; busy_o = 1'b0;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        tick();
        if (ch_ready != 2'b00) got = 1'b1;
      end
      exp = pick(2, 8'b11, m_ptr);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL cont_timeout: grant %0d no ready within 8 cycles", g);
      end else if (ch_ready !== 2'(1 << exp) || int'(grant_id) != exp) begin
        n_bad++; $display("FAIL cont_grant%0d: got ready %b id %0d want ch %0d", g, ch_ready, grant_id, exp);
      end
      m_ptr = (exp + 1) % 2;
    end
    ch_req = 2'b00;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_gating;
    int seen;
    seen = 0;
    enable = 1'b0;
    ch_req = 2'b01; ch_wen = 2'b00; ch_addr[0] = 32'h08;
    ramload_drv = 32'hCAFE_F00D; busy_o = 1'b0;
    repeat (10) begin
      tick();
      if (Ren || arb_busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL gate_idle: got %0d active cycles want 0", seen); end
    enable = 1'b1;
    tick();
    n_cmp++; if (Ren !== 1'b1) begin n_bad++; $display("FAIL gate_resume: got Ren %b want 1", Ren); end
    tick();
    enable = 1'b0; busy_o = 1'b1;
    tick();
    busy_o = 1'b0;
    tick();
    n_cmp++; if (ch_ready !== 2'b01) begin n_bad++; $display("FAIL gate_finish: got %b want 01", ch_ready); end
    n_cmp++; if (ch_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL gate_data: got %h want cafef00d", ch_rdata); end
    seen = 0;
    repeat (3) begin
      tick();
      if (Ren || arb_busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL gate_hold_idle: got %0d active cycles want 0", seen); end
    ch_req = 2'b00; enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_midop;
    int seen;
    seen = 0;
    ch_req = 2'b01; ch_wen = 2'b00; ch_addr[0] = 32'h0C;
    busy_o = 1'b1; ramload_drv = 32'h5555_5555;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", arb_busy); end
    n_cmp++; if ({Ren, Wen} !== 2'b00) begin n_bad++; $display("FAIL rstmid_strobes: got %b want 00", {Ren, Wen}); end
    n_cmp++; if (ch_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid_ready: got %b want 00", ch_ready); end
    rst = 1'b0; ch_req = 2'b00; busy_o = 1'b0;
    repeat (4) begin
      tick();
      if (ch_ready != 2'b00) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_abandon: got %0d ready pulses want 0", seen); end
  endtask

  task automatic test_random;
    logic [31:0] ref_mem [16];
    int          pa [2];
    bit          pw [2];
    logic [31:0] pd [2];
    logic [1:0]  req_before;
    int          m_ptr, cur, exp;
    bit          prev_busy;
    for (int i = 0; i < 16; i++) ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    use_auto = 1'b1; ram_init = 1'b1;
    tick();
    ram_init = 1'b0;
    pulse_rst();
    m_ptr = 0; cur = -1; prev_busy = 1'b0;
    ch_req = 2'b00; enable = 1'b1;
    for (int it = 0; it < 400; it++) begin
      req_before = ch_req;
      busy_o = ($urandom_range(0, 2) == 0);
      tick();
      if (arb_busy && !prev_busy) begin
        exp = pick(2, 8'(req_before), m_ptr);
        n_cmp++;
        if (exp < 0 || int'(grant_id) != exp) begin
          n_bad++; $display("FAIL rnd_grant: got %0d want %0d (req %b)", grant_id, exp, req_before);
        end
        cur = exp;
      end
      if (ch_ready != 2'b00) begin
        n_cmp++;
        if (cur < 0 || ch_ready !== 2'(1 << cur)) begin
          n_bad++; $display("FAIL rnd_ready: got %b want channel %0d", ch_ready, cur);
        end else begin
          if (!pw[cur]) begin
            n_cmp++;
            if (ch_rdata !== ref_mem[pa[cur]]) begin
              n_bad++; $display("FAIL rnd_rdata: got %h want %h at word %0d", ch_rdata, ref_mem[pa[cur]], pa[cur]);
            end
          end else begin
            ref_mem[pa[cur]] = pd[cur];
          end
          m_ptr = (cur + 1) % 2;
          ch_req[cur] = 1'b0;
        end
        cur = -1;
      end
      prev_busy = arb_busy;
      for (int c = 0; c < 2; c++) begin
        if (!ch_req[c] && $urandom_range(0, 2) == 0) begin
          pa[c] = $urandom_range(0, 15);
          pw[c] = 1'($urandom_range(0, 1));
          pd[c] = $urandom;
          ch_addr[c] = 32'(pa[c]) << 2;
          ch_wen[c] = pw[c];
          ch_wdata[c] = pd[c];
          ch_req[c] = 1'b1;
        end
      end
    end
    ch_req = 2'b00; busy_o = 1'b0;
    repeat (6) tick();
    use_auto = 1'b0;
  endtask

  task automatic test_three_ch_wrap;
    int m_ptr;
    int exp;
    bit got;
    pulse_rst();
    m_ptr = 0;
    req3 = 3'b111;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        tick();
        if (ready3 != 3'b000) got = 1'b1;
      end
      exp = pick(3, 8'b111, m_ptr);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL ch3_timeout: grant %0d no ready within 8 cycles", g);
      end else if (ready3 !== 3'(1 << exp) || int'(grant3) != exp) begin
        n_bad++; $display("FAIL ch3_grant%0d: got ready %b id %0d want ch %0d", g, ready3, grant3, exp);
      end
      m_ptr = (exp + 1) % 3;
    end
    req3 = 3'b000;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_gating();
    test_reset_midop();
    test_random();
    test_three_ch_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
